// File: rtl/add_scheduler_pkg.sv
// add_scheduler_pkg: shared constants and carry fix-up helper for the byte-serial add scheduler
package add_scheduler_pkg;

    localparam int BYTE_W = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // The shared adder has no carry-in, so the chained carry is folded in after it.
    // Returns {carry_next, byte_sum}; CO and the fix-up carry can never both be set.
    function automatic logic [BYTE_W:0] carry_fix(input logic [BYTE_W-1:0] sum,
                                                  input logic co,
                                                  input logic c);
        return {co | ((sum == 8'hFF) & c), sum + {7'd0, c}};
    endfunction

endpackage

// File: rtl/add_rr_arb2.sv
// add_rr_arb2: two-input round-robin arbiter, favours the requester not served last
module add_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    assign grant_o[0] = valid_i[0] & (~valid_i[1] | last_i);
    assign grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_i);

endmodule

// File: rtl/adder.sv
// adder: existing 8-bit adder shared by the scheduler (no carry-in)
module adder (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] SUM,
    output logic       CO
);

    assign {CO, SUM} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/add_scheduler.sv
// add_scheduler: round-robin sharing of one 8-bit adder for byte-serial multi-byte adds
// Optional subtract mode is enabled by defining ADD_SCHEDULER_SUB_EN.
module add_scheduler
    import add_scheduler_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = BYTE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef ADD_SCHEDULER_SUB_EN
    input  logic         req0_sub,
    input  logic         req1_sub,
`endif
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_co,
    output logic         rsp_id
);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, rsp_sum_q, rsp_sum_d;
    logic           id_q, id_d, c_q, c_d, last_q, last_d;
    logic           rsp_co_q, rsp_co_d, rsp_id_q, rsp_id_d;
    logic [2:0]     idx_q, idx_d;
    logic [1:0]     grant;
    logic           take, sel1, last_byte, sub_in, sub_q;
    logic [5:0]     sh;
    logic [W-1:0]   a_sh, b_sh, acc_merge;
    logic [7:0]     byte_a, byte_b, add_sum;
    logic           add_co;
    logic [BYTE_W:0] fix;

    add_rr_arb2 u_arb (
        .valid_i ({req1_valid, req0_valid}),
        .last_i  (last_q),
        .grant_o (grant)
    );

    assign take       = (state_q == ST_IDLE) & (|grant);
    assign sel1       = grant[1];
    assign req0_ready = (state_q == ST_IDLE) & grant[0];
    assign req1_ready = (state_q == ST_IDLE) & grant[1];

`ifdef ADD_SCHEDULER_SUB_EN
    assign sub_in = sel1 ? req1_sub : req0_sub;

    // Subtract flag travels with the operands for the whole operation
    always_ff @(posedge clk) begin
        if (!rst_n)
            sub_q <= 1'b0;
        else if (take)
            sub_q <= sub_in;
    end
`else
    assign sub_in = 1'b0;
    assign sub_q  = 1'b0;
`endif

    assign sh        = {idx_q, 3'b000};
    assign a_sh      = a_q >> sh;
    assign b_sh      = b_q >> sh;
    assign byte_a    = a_sh[7:0];
    assign byte_b    = sub_q ? ~b_sh[7:0] : b_sh[7:0];
    assign last_byte = (idx_q == 3'(NBYTES - 1));

    adder u_adder (
        .A   (byte_a),
        .B   (byte_b),
        .SUM (add_sum),
        .CO  (add_co)
    );

    assign fix       = carry_fix(add_sum, add_co, c_q);
    assign acc_merge = (acc_q & ~(W'(8'hFF) << sh)) | (W'(fix[7:0]) << sh);

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_sum   = rsp_sum_q;
    assign rsp_co    = rsp_co_q;
    assign rsp_id    = rsp_id_q;

    // Next-state: accept in IDLE, one byte per RUN cycle, hold the response in DONE
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        c_d       = c_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        rsp_sum_d = rsp_sum_q;
        rsp_co_d  = rsp_co_q;
        rsp_id_d  = rsp_id_q;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: if (take) begin
                state_d = ST_RUN;
                a_d     = sel1 ? req1_a : req0_a;
                b_d     = sel1 ? req1_b : req0_b;
                id_d    = sel1 ? REQ1 : REQ0;
                c_d     = sub_in;
                idx_d   = 3'd0;
                acc_d   = '0;
            end
            ST_RUN: begin
                acc_d = acc_merge;
                c_d   = fix[BYTE_W];
                idx_d = idx_q + 3'd1;
                if (last_byte) begin
                    state_d   = ST_DONE;
                    rsp_sum_d = acc_merge;
                    rsp_co_d  = fix[BYTE_W];
                    rsp_id_d  = id_q;
                end
            end
            ST_DONE: if (rsp_ready) begin
                state_d = ST_IDLE;
                last_d  = rsp_id_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight add and favours requester 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= REQ0;
            c_q       <= 1'b0;
            idx_q     <= 3'd0;
            acc_q     <= '0;
            rsp_sum_q <= '0;
            rsp_co_q  <= 1'b0;
            rsp_id_q  <= REQ0;
            last_q    <= REQ1;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= id_d;
            c_q       <= c_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_co_q  <= rsp_co_d;
            rsp_id_q  <= rsp_id_d;
            last_q    <= last_d;
        end
    end

endmodule
